// File: rtl/bidir_link_ctrl_if.sv
// Request/response bundle between the core bus logic and the single-wire link controller.
// The core side uses master; the controller uses slave.
interface bidir_link_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rd;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;

    modport master (
        output req_valid, req_rd, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout
    );

    modport slave (
        input  req_valid, req_rd, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout
    );
endinterface

// File: rtl/bidir_link_ctrl.sv
// Initiator for a half-duplex single-wire link: it sends a start bit and then the payload MSB first.
// For a read it releases the wire, hunts for the responder's start bit and then shifts in the reply.
module bidir_link_ctrl #(
    parameter int DATA_W   = 8,
    parameter int TURN_CYC = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bidir_link_ctrl_if.slave       bus,
    output logic                   busy,
    output logic                   pad_oe,
    output logic                   pad_out,
    input  logic                   pad_in
);
    localparam int CNT_W = $clog2(DATA_W + TURN_CYC + TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BITS = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_TURN = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_HUNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SEND  = 3'd2,
        S_TURN  = 3'd3,
        S_HUNT  = 3'd4,
        S_RECV  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic              rd_r, rd_s;
    logic              oe_r, oe_s;
    logic              out_r, out_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              timeout_r, timeout_s;

    assign bus.req_ready   = (state_r == S_IDLE);
    assign busy            = (state_r != S_IDLE);
    assign pad_oe          = oe_r;
    assign pad_out         = out_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rdata_r;
    assign bus.rsp_timeout = timeout_r;

    // Next-state, datapath and next pad/response values.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        shift_s   = shift_r;
        rd_s      = rd_r;
        rdata_s   = rdata_r;
        timeout_s = timeout_r;
        case (state_r)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_s = S_START;
                    shift_s = bus.req_wdata;
                    rd_s    = bus.req_rd;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                state_s = S_SEND;
                cnt_s   = CNT_BITS;
            end
            S_SEND: begin
                shift_s = {shift_r[DATA_W-2:0], 1'b0};
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (rd_r) begin
                    state_s = S_TURN;
                    cnt_s   = CNT_TURN;
                end else begin
                    state_s   = S_DONE;
                    rdata_s   = {DATA_W{1'b0}};
                    timeout_s = 1'b0;
                end
            end
            S_TURN: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    state_s = S_HUNT;
                    cnt_s   = CNT_ZERO;
                end
            end
            S_HUNT: begin
                if (pad_in) begin
                    state_s = S_RECV;
                    cnt_s   = CNT_BITS;
                end else if (cnt_r == CNT_HUNT) begin
                    state_s   = S_DONE;
                    rdata_s   = {DATA_W{1'b0}};
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_RECV: begin
                shift_s = {shift_r[DATA_W-2:0], pad_in};
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    state_s   = S_DONE;
                    rdata_s   = shift_s;
                    timeout_s = 1'b0;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Pad and pulse outputs are computed from the next state so the registers line up with it.
        oe_s        = (state_s == S_START) || (state_s == S_SEND);
        rsp_valid_s = (state_s == S_DONE);
        if (state_s == S_START) begin
            out_s = 1'b1;
        end else if (state_s == S_SEND) begin
            out_s = shift_s[DATA_W-1];
        end else begin
            out_s = 1'b0;
        end
    end

    // State, datapath and registered outputs; reset releases the wire at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= CNT_ZERO;
            shift_r     <= {DATA_W{1'b0}};
            rd_r        <= 1'b0;
            oe_r        <= 1'b0;
            out_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            shift_r     <= shift_s;
            rd_r        <= rd_s;
            oe_r        <= oe_s;
            out_r       <= out_s;
            rsp_valid_r <= rsp_valid_s;
            rdata_r     <= rdata_s;
            timeout_r   <= timeout_s;
        end
    end
endmodule
